// File: rtl/sdiv_pkg.sv
// Shared definitions for the iterative signed divider: default widths and FSM states.
package sdiv_pkg;

   localparam int DW_DEF = 8;
   localparam int VW_DEF = 4;
   localparam int CW_DEF = $clog2(DW_DEF);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      FIN
   } state_e;

endpackage

// File: rtl/sdiv_fa.sv
// Single-bit full-adder cell; the building block of the divider's ripple subtractor.
module sdiv_fa (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);

   assign s_o = a_i ^ b_i ^ c_i;
   assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/sdiv_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract
// |divisor| with a ripple of full adders, keep or restore the partial remainder.
module sdiv_step
   import sdiv_pkg::*;
#(
   parameter int VW = VW_DEF
) (
   input  logic [VW:0] rem_i,
   input  logic        bit_i,
   input  logic [VW:0] dvs_i,
   output logic [VW:0] rem_o,
   output logic        qbit_o
);

   logic [VW:0]   shifted;
   logic [VW:0]   dvs_n;
   logic [VW:0]   diff;
   logic [VW+1:0] carry;

   assign shifted  = {rem_i[VW-1:0], bit_i};
   assign dvs_n    = ~dvs_i;
   assign carry[0] = 1'b1;

   // shifted + ~dvs + 1: a final carry of 1 means no borrow, i.e. shifted >= |divisor|
   for (genvar i = 0; i <= VW; i++) begin : g_sub
      sdiv_fa u_fa (
         .a_i (shifted[i]),
         .b_i (dvs_n[i]),
         .c_i (carry[i]),
         .s_o (diff[i]),
         .c_o (carry[i+1])
      );
   end

   // A set bit shifted out of the top would make the trial value larger than any divisor
   assign qbit_o = carry[VW+1] | rem_i[VW];
   assign rem_o  = qbit_o ? diff : shifted;

endmodule

// File: rtl/seq_sdiv.sv
// Multi-cycle signed restoring divider with start/done handshake; truncates toward
// zero, remainder carries the dividend's sign, flags divide-by-zero and overflow.
module seq_sdiv
   import sdiv_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int VW = VW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] q,
   output logic [VW-1:0] r,
   output logic          div_zero,
   output logic          ovf
);

   localparam int CW = $clog2(DW);
   localparam logic [DW-1:0] MIN_DVD = {1'b1, {(DW-1){1'b0}}};

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [VW:0]   rem_q, rem_d;
   logic [DW-1:0] dvd_q, dvd_d;
   logic [VW:0]   dvs_q, dvs_d;
   logic          qneg_q, qneg_d;
   logic          rneg_q, rneg_d;
   logic [DW-1:0] quot_q, quot_d;
   logic [VW-1:0] remo_q, remo_d;
   logic          dz_q, dz_d;
   logic          ovf_q, ovf_d;

   logic [DW-1:0] dvd_abs;
   logic [VW:0]   dvs_ext;
   logic [VW:0]   dvs_abs;
   logic [VW:0]   step_rem;
   logic          step_qbit;

   assign dvd_abs = dividend[DW-1] ? -dividend : dividend;
   assign dvs_ext = {divisor[VW-1], divisor};
   assign dvs_abs = dvs_ext[VW] ? -dvs_ext : dvs_ext;

   // dvd_q doubles as the quotient register: dividend bits leave at the top while
   // quotient bits enter at the bottom, so after DW steps it holds |quotient|.
   sdiv_step #(.VW(VW)) u_step (
      .rem_i  (rem_q),
      .bit_i  (dvd_q[DW-1]),
      .dvs_i  (dvs_q),
      .rem_o  (step_rem),
      .qbit_o (step_qbit)
   );

   // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values;
   // the combinational block below uses blocking (=) since it is evaluated in order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         quot_q  <= '0;
         remo_q  <= '0;
         dz_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         quot_q  <= quot_d;
         remo_q  <= remo_d;
         dz_q    <= dz_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      // NOTE: every next-state signal holds its current value by default; a path that
      // left one unassigned would infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      quot_d  = quot_q;
      remo_d  = remo_q;
      dz_d    = dz_q;
      ovf_d   = ovf_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               dvd_d  = dvd_abs;
               dvs_d  = dvs_abs;
               qneg_d = dividend[DW-1] ^ divisor[VW-1];
               rneg_d = dividend[DW-1];
               dz_d   = 1'b0;
               ovf_d  = 1'b0;
               if (divisor == '0) begin
                  state_d = FIN;
                  quot_d  = '0;
                  remo_d  = '0;
                  dz_d    = 1'b1;
               end else if (dividend == MIN_DVD && divisor == '1) begin
                  state_d = FIN;
                  quot_d  = MIN_DVD;
                  remo_d  = '0;
                  ovf_d   = 1'b1;
               end else begin
                  state_d = CALC;
                  cnt_d   = CW'(DW - 1);
                  rem_d   = '0;
               end
            end
         end
         CALC: begin
            rem_d = step_rem;
            dvd_d = {dvd_q[DW-2:0], step_qbit};
            if (cnt_q == '0) begin
               state_d = FIX;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         FIX: begin
            // Remainder magnitude is below |divisor| <= 2^(VW-1), so VW bits suffice
            quot_d  = qneg_q ? -dvd_q : dvd_q;
            remo_d  = rneg_q ? -rem_q[VW-1:0] : rem_q[VW-1:0];
            state_d = FIN;
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy     = (state_q != IDLE);
   assign done     = (state_q == FIN);
   assign q        = quot_q;
   assign r        = remo_q;
   assign div_zero = dz_q;
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_seq_sdiv.sv
// Directed-vector bench for seq_sdiv: latency, handshake, signs, exceptions, abort.
module tb_seq_sdiv;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] dividend;
   logic [3:0] divisor;
   logic       busy;
   logic       done;
   logic [7:0] q;
   logic [3:0] r;
   logic       div_zero;
   logic       ovf;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      logic [7:0] a;
      logic [3:0] b;
      int         lat;
      logic [7:0] q;
      logic [3:0] r;
      logic       dz;
      logic       ovf;
   } vec_t;

   seq_sdiv dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .dividend (dividend),
      .divisor  (divisor),
      .busy     (busy),
      .done     (done),
      .q        (q),
      .r        (r),
      .div_zero (div_zero),
      .ovf      (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Starts one operation from IDLE and watches 16 cycles; k counts cycles after the accepting edge.
   task automatic do_op(input logic [7:0] a, input logic [3:0] b,
                        output int lat, output int nd, output int busy_err);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
      dividend = ~a;
      divisor  = ~b;
      lat      = -1;
      nd       = 0;
      busy_err = 0;
      for (int k = 1; k <= 16; k++) begin
         if (done === 1'b1) begin
            nd++;
            if (lat < 0) lat = k;
         end
         if (busy !== ((lat < 0) || (lat == k))) busy_err++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; dividend = 8'h00; divisor = 4'h0;
      #1;
      vectors++;
      if ({busy, done, q, r, div_zero, ovf} !== 16'h0000) begin
         $display("FAIL reset_state: got busy=%b done=%b q=%h r=%h dz=%b ovf=%b, want all 0",
                  busy, done, q, r, div_zero, ovf);
         miscompares++;
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if ({busy, done} !== 2'b00) begin
         $display("FAIL reset_release: got busy=%b done=%b, want 0 0", busy, done);
         miscompares++;
      end
   endtask

   task automatic test_divide;
      vec_t tbl[6];
      int lat, nd, berr;
      tbl[0] = '{8'd100, 4'd7, 10, 8'h0E, 4'h2, 1'b0, 1'b0};
      tbl[1] = '{8'h9C,  4'd7, 10, 8'hF2, 4'hE, 1'b0, 1'b0};
      tbl[2] = '{8'd100, 4'h8, 10, 8'hF4, 4'h4, 1'b0, 1'b0};
      tbl[3] = '{8'hF9,  4'd2, 10, 8'hFD, 4'hF, 1'b0, 1'b0};
      tbl[4] = '{8'd7,   4'h8, 10, 8'h00, 4'h7, 1'b0, 1'b0};
      tbl[5] = '{8'h7F,  4'd1, 10, 8'h7F, 4'h0, 1'b0, 1'b0};
      foreach (tbl[i]) begin
         do_op(tbl[i].a, tbl[i].b, lat, nd, berr);
         vectors++;
         if (lat !== tbl[i].lat || nd !== 1) begin
            $display("FAIL divide[%0d] latency: got lat=%0d pulses=%0d, want lat=%0d pulses=1",
                     i, lat, nd, tbl[i].lat);
            miscompares++;
         end
         vectors++;
         if (berr !== 0) begin
            $display("FAIL divide[%0d] busy: got %0d bad cycles, want 0", i, berr);
            miscompares++;
         end
         vectors++;
         if ({q, r, div_zero, ovf} !== {tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].ovf}) begin
            $display("FAIL divide[%0d] result: got q=%h r=%h dz=%b ovf=%b, want q=%h r=%h dz=%b ovf=%b",
                     i, q, r, div_zero, ovf, tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].ovf);
            miscompares++;
         end
      end
   endtask

   task automatic test_exceptions;
      vec_t tbl[5];
      int lat, nd, berr;
      tbl[0] = '{8'h80,  4'hF, 1,  8'h80, 4'h0, 1'b0, 1'b1};
      tbl[1] = '{8'd20,  4'd3, 10, 8'h06, 4'h2, 1'b0, 1'b0};
      tbl[2] = '{8'd55,  4'h0, 1,  8'h00, 4'h0, 1'b1, 1'b0};
      tbl[3] = '{8'h80,  4'd1, 10, 8'h80, 4'h0, 1'b0, 1'b0};
      tbl[4] = '{8'h80,  4'h8, 10, 8'h10, 4'h0, 1'b0, 1'b0};
      foreach (tbl[i]) begin
         do_op(tbl[i].a, tbl[i].b, lat, nd, berr);
         vectors++;
         if (lat !== tbl[i].lat || nd !== 1) begin
            $display("FAIL except[%0d] latency: got lat=%0d pulses=%0d, want lat=%0d pulses=1",
                     i, lat, nd, tbl[i].lat);
            miscompares++;
         end
         vectors++;
         if (berr !== 0) begin
            $display("FAIL except[%0d] busy: got %0d bad cycles, want 0", i, berr);
            miscompares++;
         end
         vectors++;
         if ({q, r, div_zero, ovf} !== {tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].ovf}) begin
            $display("FAIL except[%0d] result: got q=%h r=%h dz=%b ovf=%b, want q=%h r=%h dz=%b ovf=%b",
                     i, q, r, div_zero, ovf, tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].ovf);
            miscompares++;
         end
      end
      // Results must hold through IDLE while the inputs wander
      for (int k = 0; k < 5; k++) begin
         dividend = 8'(k * 37);
         divisor  = 4'(k + 5);
         @(posedge clk); #1;
      end
      vectors++;
      if ({q, r, div_zero, ovf, busy} !== {8'h10, 4'h0, 1'b0, 1'b0, 1'b0}) begin
         $display("FAIL hold_idle: got q=%h r=%h dz=%b ovf=%b busy=%b, want q=10 r=0 dz=0 ovf=0 busy=0",
                  q, r, div_zero, ovf, busy);
         miscompares++;
      end
   endtask

   task automatic test_back_to_back;
      int lat, nd;
      dividend = 8'd20;
      divisor  = 4'd3;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat   = -1;
      nd    = 0;
      for (int k = 1; k <= 16; k++) begin
         if (done === 1'b1) begin
            nd++;
            if (lat < 0) lat = k;
         end
         start = (k == 4) || (done === 1'b1);
         if (start) begin
            dividend = 8'd50;
            divisor  = 4'd5;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      vectors++;
      if (lat !== 10 || nd !== 1) begin
         $display("FAIL back_to_back handshake: got lat=%0d pulses=%0d, want lat=10 pulses=1", lat, nd);
         miscompares++;
      end
      vectors++;
      if ({q, r, busy} !== {8'h06, 4'h2, 1'b0}) begin
         $display("FAIL back_to_back result: got q=%h r=%h busy=%b, want q=06 r=2 busy=0", q, r, busy);
         miscompares++;
      end
   endtask

   task automatic test_abort;
      int lat, nd, berr;
      dividend = 8'd100;
      divisor  = 4'd7;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({busy, done, q, r, div_zero, ovf} !== 16'h0000) begin
         $display("FAIL abort_state: got busy=%b done=%b q=%h r=%h dz=%b ovf=%b, want all 0",
                  busy, done, q, r, div_zero, ovf);
         miscompares++;
      end
      nd = 0;
      for (int k = 0; k < 12; k++) begin
         if (k == 3) rst_n = 1'b1;
         if (done === 1'b1) nd++;
         @(posedge clk); #1;
      end
      vectors++;
      if (nd !== 0) begin
         $display("FAIL abort_no_done: got %0d pulses, want 0", nd);
         miscompares++;
      end
      do_op(8'd100, 4'd7, lat, nd, berr);
      vectors++;
      if (lat !== 10 || nd !== 1 || berr !== 0) begin
         $display("FAIL abort_rerun handshake: got lat=%0d pulses=%0d busy_err=%0d, want 10 1 0",
                  lat, nd, berr);
         miscompares++;
      end
      vectors++;
      if ({q, r} !== {8'h0E, 4'h2}) begin
         $display("FAIL abort_rerun result: got q=%h r=%h, want q=0E r=2", q, r);
         miscompares++;
      end
   endtask

   initial begin
      test_reset();
      test_divide();
      test_exceptions();
      test_back_to_back();
      test_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
